// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
//  - ALU_SEL_* op codes presented by EX on op_sel (MIPS funct encoding)
//  - op decode into an operation class plus a signedness flag
//  - 32x32->64 multiply helper, signed or unsigned
package hilo_muldiv_ctrl_pkg;

    localparam logic [5:0] ALU_SEL_MTHI  = 6'h11;
    localparam logic [5:0] ALU_SEL_MTLO  = 6'h13;
    localparam logic [5:0] ALU_SEL_MULT  = 6'h18;
    localparam logic [5:0] ALU_SEL_MULTU = 6'h19;
    localparam logic [5:0] ALU_SEL_DIV   = 6'h1A;
    localparam logic [5:0] ALU_SEL_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MUL,
        OP_DIV,
        OP_MTHI,
        OP_MTLO
    } op_kind_e;

    typedef struct packed {
        op_kind_e kind;
        logic     is_signed;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [5:0] sel);
        op_dec_t d;
        d.kind      = OP_NONE;
        d.is_signed = 1'b0;
        case (sel)
            ALU_SEL_MULT:  begin d.kind = OP_MUL;  d.is_signed = 1'b1; end
            ALU_SEL_MULTU: begin d.kind = OP_MUL;  d.is_signed = 1'b0; end
            ALU_SEL_DIV:   begin d.kind = OP_DIV;  d.is_signed = 1'b1; end
            ALU_SEL_DIVU:  begin d.kind = OP_DIV;  d.is_signed = 1'b0; end
            ALU_SEL_MTHI:  d.kind = OP_MTHI;
            ALU_SEL_MTLO:  d.kind = OP_MTLO;
            default:       d.kind = OP_NONE;
        endcase
        return d;
    endfunction

    // Sign- or zero-extend both operands to 64 bits; the low 64 bits of the
    // product are then correct for both interpretations.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{is_signed & a[31]}}, a};
        eb = {{32{is_signed & b[31]}}, b};
        return ea * eb;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX <-> HI/LO controller bus.
//  master (EX side):  drives op_valid, op_sel, src_a, src_b, flush
//  slave (controller): drives op_ready, stall_req, busy, done, hi, lo
interface hilo_muldiv_ctrl_if;
    logic        op_valid;
    logic [5:0]  op_sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        op_ready;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op_sel, src_a, src_b, flush,
        input  op_ready, stall_req, busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op_sel, src_a, src_b, flush,
        output op_ready, stall_req, busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_div_core.sv
// Restoring divider datapath: operand absolute values, one shift-subtract
// step per cycle, sign fix on the outputs.
//  clk, rst    clock / async active-low reset
//  prep        first step: load |a|,|b| and sign flags, perform step 0
//  iter        perform one further step on the held state
//  a, b        raw dividend / divisor (held stable by the controller)
//  is_signed   DIV (1) or DIVU (0)
//  quotient    signed-corrected quotient of the held state
//  remainder   signed-corrected remainder (sign follows dividend)
module hilo_div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        prep,
    input  logic        iter,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;

    logic [31:0] abs_a, abs_b;
    logic [31:0] rem_in, quo_in, dvs_in;
    logic [32:0] trial;

    // The step works on fresh operands in the prep cycle and on the held
    // state afterwards. rem < divisor always holds, so {rem, next bit} fits
    // in 33 bits and trial[32] is a reliable borrow flag.
    always_comb begin
        abs_a  = (is_signed & a[31]) ? -a : a;
        abs_b  = (is_signed & b[31]) ? -b : b;
        rem_in = prep ? 32'd0 : rem_q;
        quo_in = prep ? abs_a : quo_q;
        dvs_in = prep ? abs_b : dvs_q;
        trial  = {rem_in, quo_in[31]} - {1'b0, dvs_in};
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        if (prep || iter) begin
            rem_d = trial[32] ? {rem_in[30:0], quo_in[31]} : trial[31:0];
            quo_d = {quo_in[30:0], ~trial[32]};
            dvs_d = dvs_in;
        end
        if (prep) begin
            q_neg_d = is_signed & (a[31] ^ b[31]);
            r_neg_d = is_signed & a[31];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    assign quotient  = q_neg_q ? -quo_q : quo_q;
    assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  clk    single clock
//  rst    asynchronous active-low reset
//  bus    slave side of hilo_muldiv_ctrl_if (op handshake, stall, hi/lo)
// One op at a time is accepted from IDLE. Multiplies commit MUL_LAT cycles
// after accept, divides (non-zero divisor) 34 cycles after accept, and
// MTHI/MTLO and divide-by-zero commit at the accept edge.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input logic               clk,
    input logic               rst,
    hilo_muldiv_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_PREP,
        S_DIV_ITER,
        S_DIV_FIX
    } state_e;

    // Counters hold the number of further cycles before the commit cycle.
    // MUL spends MUL_LAT-1 cycles in S_MUL; the divider does step 0 in
    // S_DIV_PREP and the remaining 31 steps in S_DIV_ITER.
    localparam logic [4:0] MUL_CNT_INIT = (MUL_LAT >= 2) ? 5'(MUL_LAT - 2) : 5'd0;
    localparam logic [4:0] DIV_CNT_INIT = 5'd30;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    op_dec_t     dec;
    logic        accept;
    logic        stall_req;
    logic        done;
    logic [63:0] product;
    logic [31:0] div_quo, div_rem;

    assign dec     = decode_op(bus.op_sel);
    assign product = mul64(bus.src_a, bus.src_b, dec.is_signed);
    assign accept  = bus.op_valid && (dec.kind != OP_NONE) && (state_q == S_IDLE) && !bus.flush;

    hilo_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .prep      (state_q == S_DIV_PREP),
        .iter      (state_q == S_DIV_ITER),
        .a         (a_q),
        .b         (b_q),
        .is_signed (sgn_q),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall_req = 1'b0;
        done      = 1'b0;

        if (bus.flush) begin
            // Kill whatever is in flight; any commit this cycle is dropped.
            state_d   = S_IDLE;
            stall_req = (state_q != S_IDLE);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (dec.kind)
                            OP_MUL: begin
                                if (MUL_LAT == 1) begin
                                    {hi_d, lo_d} = product;
                                    done         = 1'b1;
                                end else begin
                                    prod_d    = product;
                                    cnt_d     = MUL_CNT_INIT;
                                    state_d   = S_MUL;
                                    stall_req = 1'b1;
                                end
                            end
                            OP_DIV: begin
                                if (bus.src_b == 32'd0) begin
                                    hi_d = bus.src_a;
                                    lo_d = 32'hFFFF_FFFF;
                                    done = 1'b1;
                                end else begin
                                    a_d       = bus.src_a;
                                    b_d       = bus.src_b;
                                    sgn_d     = dec.is_signed;
                                    state_d   = S_DIV_PREP;
                                    stall_req = 1'b1;
                                end
                            end
                            OP_MTHI: hi_d = bus.src_a;
                            OP_MTLO: lo_d = bus.src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == 5'd0) begin
                        {hi_d, lo_d} = prod_q;
                        done         = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d     = cnt_q - 5'd1;
                        stall_req = 1'b1;
                    end
                end
                S_DIV_PREP: begin
                    cnt_d     = DIV_CNT_INIT;
                    state_d   = S_DIV_ITER;
                    stall_req = 1'b1;
                end
                S_DIV_ITER: begin
                    stall_req = 1'b1;
                    if (cnt_q == 5'd0) begin
                        state_d = S_DIV_FIX;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                S_DIV_FIX: begin
                    lo_d    = div_quo;
                    hi_d    = div_rem;
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.op_ready  = accept;
    assign bus.stall_req = stall_req;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl (MUL_LAT=2). Inputs change just after
// the falling edge; outputs are sampled 1ns later, well away from posedge.
// "Cycle 0" is the cycle an op is presented; its closing posedge accepts it.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    hilo_muldiv_ctrl_if bus ();

    hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic present(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.op_sel   = sel;
        bus.src_a    = a;
        bus.src_b    = b;
    endtask

    task automatic idle();
        bus.op_valid = 1'b0;
        bus.op_sel   = 6'h00;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
    endtask

    // Full non-zero-divisor divide: done in cycle 33, result in cycle 34.
    task automatic run_div(input string tag, input logic [5:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        tick(); present(sel, a, b); #1;
        check({tag, "_ready"}, 64'(bus.op_ready), 64'd1);
        for (int k = 1; k <= 32; k++) begin
            tick(); idle();
        end
        tick(); #1;
        check({tag, "_done33"}, 64'(bus.done), 64'd1);
        tick(); #1;
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    endtask

    initial begin
        int bad;
        rst       = 1'b0;
        bus.flush = 1'b0;
        idle();

        // Reset state
        tick(); tick(); #1;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_stall", 64'(bus.stall_req), 64'd0);
        check("rst_ready", 64'(bus.op_ready), 64'd0);
        tick(); rst = 1'b1;

        // MULT -2 * 3: done in cycle 1, result visible in cycle 2
        tick(); present(ALU_SEL_MULT, 32'hFFFF_FFFE, 32'd3); #1;
        check("mult_ready", 64'(bus.op_ready), 64'd1);
        check("mult_stall0", 64'(bus.stall_req), 64'd1);
        check("mult_done0", 64'(bus.done), 64'd0);
        tick(); idle(); #1;
        check("mult_busy1", 64'(bus.busy), 64'd1);
        check("mult_done1", 64'(bus.done), 64'd1);
        check("mult_stall1", 64'(bus.stall_req), 64'd0);
        check("mult_hi_pre", 64'(bus.hi), 64'd0);
        tick(); #1;
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);
        check("mult_done2", 64'(bus.done), 64'd0);
        check("mult_busy2", 64'(bus.busy), 64'd0);

        // MULTU same operands: 3 * (2^32-2) = 0x2_FFFF_FFFA
        tick(); present(ALU_SEL_MULTU, 32'hFFFF_FFFE, 32'd3); #1;
        tick(); idle();
        tick(); #1;
        check("multu_hi", 64'(bus.hi), 64'd2);
        check("multu_lo", 64'(bus.lo), 64'hFFFF_FFFA);

        // DIVU 100/7 with an MTHI held on the bus while busy
        tick(); present(ALU_SEL_DIVU, 32'd100, 32'd7); #1;
        check("divu_ready", 64'(bus.op_ready), 64'd1);
        check("divu_stall0", 64'(bus.stall_req), 64'd1);
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            tick(); present(ALU_SEL_MTHI, 32'h5555, 32'd0); #1;
            if (bus.op_ready !== 1'b0 || bus.stall_req !== 1'b1 ||
                bus.done !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        check("divu_busy_window", 64'(bad), 64'd0);
        tick(); #1;
        check("divu_done33", 64'(bus.done), 64'd1);
        check("divu_stall33", 64'(bus.stall_req), 64'd0);
        check("mthi_blocked33", 64'(bus.op_ready), 64'd0);
        tick(); #1;
        check("divu_lo", 64'(bus.lo), 64'd14);
        check("divu_hi", 64'(bus.hi), 64'd2);
        check("divu_done34", 64'(bus.done), 64'd0);
        check("mthi_accept34", 64'(bus.op_ready), 64'd1);
        tick(); idle(); #1;
        check("mthi_hi", 64'(bus.hi), 64'h5555);
        check("mthi_lo_kept", 64'(bus.lo), 64'd14);

        // Signed and unsigned divide corners
        run_div("div_m7_2", ALU_SEL_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2", ALU_SEL_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("div_ovf", ALU_SEL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("divu_max", ALU_SEL_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);
        run_div("divu_bigdvs", ALU_SEL_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Divide by zero: immediate commit, no stall
        tick(); present(ALU_SEL_DIV, 32'h1234, 32'd0); #1;
        check("div0_ready", 64'(bus.op_ready), 64'd1);
        check("div0_stall", 64'(bus.stall_req), 64'd0);
        check("div0_done", 64'(bus.done), 64'd1);
        tick(); idle(); #1;
        check("div0_hi", 64'(bus.hi), 64'h1234);
        check("div0_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        check("div0_busy", 64'(bus.busy), 64'd0);

        // MTLO leaves HI alone
        tick(); present(ALU_SEL_MTLO, 32'h77, 32'd0); #1;
        check("mtlo_done", 64'(bus.done), 64'd0);
        tick(); idle(); #1;
        check("mtlo_lo", 64'(bus.lo), 64'h77);
        check("mtlo_hi_kept", 64'(bus.hi), 64'h1234);

        // Flush alongside op_valid: not accepted
        tick(); present(ALU_SEL_MTHI, 32'hDEAD, 32'd0); bus.flush = 1'b1; #1;
        check("flush_op_ready", 64'(bus.op_ready), 64'd0);
        tick(); idle(); bus.flush = 1'b0; #1;
        check("flush_op_hi", 64'(bus.hi), 64'h1234);

        // Flush mid-divide (step 10, cycle 11), then MTLO next cycle
        tick(); present(ALU_SEL_DIVU, 32'd100, 32'd7); #1;
        for (int k = 1; k <= 10; k++) begin
            tick(); idle();
        end
        tick(); bus.flush = 1'b1; #1;
        check("flush_div_done", 64'(bus.done), 64'd0);
        check("flush_div_stall", 64'(bus.stall_req), 64'd1);
        tick(); bus.flush = 1'b0; present(ALU_SEL_MTLO, 32'hAA, 32'd0); #1;
        check("flush_div_idle", 64'(bus.busy), 64'd0);
        check("flush_div_hi", 64'(bus.hi), 64'h1234);
        check("flush_div_lo", 64'(bus.lo), 64'h77);
        check("flush_mtlo_ready", 64'(bus.op_ready), 64'd1);
        tick(); idle(); #1;
        check("flush_mtlo_lo", 64'(bus.lo), 64'hAA);

        // Flush in the multiply commit cycle suppresses the write
        tick(); present(ALU_SEL_MULT, 32'd5, 32'd6); #1;
        tick(); idle(); bus.flush = 1'b1; #1;
        check("flush_mul_done", 64'(bus.done), 64'd0);
        tick(); bus.flush = 1'b0; #1;
        check("flush_mul_hi", 64'(bus.hi), 64'h1234);
        check("flush_mul_lo", 64'(bus.lo), 64'hAA);
        check("flush_mul_busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset during DIV_ITER
        tick(); present(ALU_SEL_DIVU, 32'd100, 32'd7); #1;
        for (int k = 1; k <= 5; k++) begin
            tick(); idle();
        end
        #2 rst = 1'b0; #1;
        check("arst_hi", 64'(bus.hi), 64'd0);
        check("arst_lo", 64'(bus.lo), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_stall", 64'(bus.stall_req), 64'd0);
        tick(); rst = 1'b1;
        tick(); present(ALU_SEL_MTHI, 32'h99, 32'd0); #1;
        check("post_rst_ready", 64'(bus.op_ready), 64'd1);
        tick(); idle(); #1;
        check("post_rst_hi", 64'(bus.hi), 64'h99);
        check("post_rst_lo", 64'(bus.lo), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
